// File: rtl/tl_a_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tl_a_arbiter
//  Purpose  : Merges two TileLink A-channel sources into a single registered
//             output stage holding one beat. Round-robin arbitration happens
//             between messages, and a two-beat Put keeps its grant locked
//             until its second beat has been accepted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset_n          : rising-edge clock, asynchronous active-low reset
//    in0_valid / in0_ready   : input 0 handshake
//    in0_opcode, in0_param,
//    in0_size, in0_address   : input 0 payload (3/3/2/9 bits)
//    in1_*                   : input 1, same shape as input 0
//    out_valid / out_ready   : downstream A-channel handshake
//    out_opcode, out_param,
//    out_size, out_address   : registered output payload
//    out_source              : index of the input that supplied the beat
//    out_last                : beat is the final beat of its message
// ============================================================================
module tl_a_arbiter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in0_valid,
    output logic       in0_ready,
    input  logic [2:0] in0_opcode,
    input  logic [2:0] in0_param,
    input  logic [1:0] in0_size,
    input  logic [8:0] in0_address,
    input  logic       in1_valid,
    output logic       in1_ready,
    input  logic [2:0] in1_opcode,
    input  logic [2:0] in1_param,
    input  logic [1:0] in1_size,
    input  logic [8:0] in1_address,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_opcode,
    output logic [2:0] out_param,
    output logic [1:0] out_size,
    output logic [8:0] out_address,
    output logic       out_source,
    output logic       out_last
);

    localparam logic [1:0] c_MULTI_SIZE = 2'd3;

    // Arbitration state
    logic       r_ptr;
    logic       r_locked;
    logic       r_lock_src;
    logic       r_beat;

    // Output register
    logic       r_out_valid;
    logic [2:0] r_out_opcode;
    logic [2:0] r_out_param;
    logic [1:0] r_out_size;
    logic [8:0] r_out_address;
    logic       r_out_source;
    logic       r_out_last;

    logic       w_grant;
    logic       w_space;
    logic       w_sel_valid;
    logic [2:0] w_sel_opcode;
    logic [2:0] w_sel_param;
    logic [1:0] w_sel_size;
    logic [8:0] w_sel_address;
    logic       w_accept;
    logic       w_multi;
    logic       w_last;

    // Grant selection. When neither input is valid the pointer is still
    // granted so that ready is always well defined.
    always_comb begin
        w_grant = r_ptr;
        if (r_locked) begin
            w_grant = r_lock_src;
        end else if (in0_valid && !in1_valid) begin
            w_grant = 1'b0;
        end else if (in1_valid && !in0_valid) begin
            w_grant = 1'b1;
        end
    end

    // The output register can take a beat if it is empty or draining now.
    assign w_space = !r_out_valid || out_ready;

    // Ready never looks at the same input's valid; the reset_n term keeps
    // both readies low for the whole time reset is held.
    assign in0_ready = reset_n && !w_grant && w_space;
    assign in1_ready = reset_n &&  w_grant && w_space;

    always_comb begin
        w_sel_valid   = in0_valid;
        w_sel_opcode  = in0_opcode;
        w_sel_param   = in0_param;
        w_sel_size    = in0_size;
        w_sel_address = in0_address;
        if (w_grant) begin
            w_sel_valid   = in1_valid;
            w_sel_opcode  = in1_opcode;
            w_sel_param   = in1_param;
            w_sel_size    = in1_size;
            w_sel_address = in1_address;
        end
    end

    assign w_accept = w_sel_valid && w_space;

    // PutFull (0) / PutPartial (1) of size 3 span two beats. The second
    // beat is always last, whatever its own opcode and size say.
    assign w_multi = (w_sel_opcode == 3'd0 || w_sel_opcode == 3'd1) &&
                     (w_sel_size == c_MULTI_SIZE);
    assign w_last  = r_beat || !w_multi;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr         <= 1'b0;
            r_locked      <= 1'b0;
            r_lock_src    <= 1'b0;
            r_beat        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_opcode  <= 3'd0;
            r_out_param   <= 3'd0;
            r_out_size    <= 2'd0;
            r_out_address <= 9'd0;
            r_out_source  <= 1'b0;
            r_out_last    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_opcode  <= w_sel_opcode;
            r_out_param   <= w_sel_param;
            r_out_size    <= w_sel_size;
            r_out_address <= w_sel_address;
            r_out_source  <= w_grant;
            r_out_last    <= w_last;
            if (r_beat) begin
                r_locked <= 1'b0;
                r_beat   <= 1'b0;
            end else if (w_multi) begin
                r_locked   <= 1'b1;
                r_lock_src <= w_grant;
                r_beat     <= 1'b1;
            end
            if (w_last) begin
                r_ptr <= !w_grant;
            end
        end else if (out_ready) begin
            // Drained with nothing new behind it; payload is left as is.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_opcode  = r_out_opcode;
    assign out_param   = r_out_param;
    assign out_size    = r_out_size;
    assign out_address = r_out_address;
    assign out_source  = r_out_source;
    assign out_last    = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_tl_a_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_a_arbiter
//  Purpose  : Self-checking bench for tl_a_arbiter: directed scenarios plus a
//             randomized run against a message-level reference model, and a
//             stability monitor on the downstream channel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tl_a_arbiter;

    logic       clock;
    logic       reset_n;
    logic       in0_valid, in0_ready;
    logic [2:0] in0_opcode, in0_param;
    logic [1:0] in0_size;
    logic [8:0] in0_address;
    logic       in1_valid, in1_ready;
    logic [2:0] in1_opcode, in1_param;
    logic [1:0] in1_size;
    logic [8:0] in1_address;
    logic       out_valid, out_ready;
    logic [2:0] out_opcode, out_param;
    logic [1:0] out_size;
    logic [8:0] out_address;
    logic       out_source, out_last;

    int n_cmp;
    int n_bad;

    tl_a_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in0_valid   (in0_valid),
        .in0_ready   (in0_ready),
        .in0_opcode  (in0_opcode),
        .in0_param   (in0_param),
        .in0_size    (in0_size),
        .in0_address (in0_address),
        .in1_valid   (in1_valid),
        .in1_ready   (in1_ready),
        .in1_opcode  (in1_opcode),
        .in1_param   (in1_param),
        .in1_size    (in1_size),
        .in1_address (in1_address),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_param   (out_param),
        .out_size    (out_size),
        .out_address (out_address),
        .out_source  (out_source),
        .out_last    (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {valid, source, last, opcode, param, size, address}
    logic [19:0] dut_out;
    logic [1:0]  dut_rdy;
    assign dut_out = {out_valid, out_source, out_last, out_opcode, out_param, out_size, out_address};
    assign dut_rdy = {in0_ready, in1_ready};

    // ---------------- reference model (message level) ----------------
    int         m_left;   // beats still owed by the message in progress
    logic       m_src;    // input owning the message in progress
    logic       m_ptr;    // preferred input for the next new message
    logic       m_ov, m_so, m_la;
    logic [2:0] m_op, m_pa;
    logic [1:0] m_sz;
    logic [8:0] m_ad;
    logic       acc0, acc1;

    task automatic model_reset();
        m_left = 0; m_src = 1'b0; m_ptr = 1'b0;
        m_ov = 1'b0; m_so = 1'b0; m_la = 1'b0;
        m_op = 3'd0; m_pa = 3'd0; m_sz = 2'd0; m_ad = 9'd0;
        acc0 = 1'b0; acc1 = 1'b0;
    endtask

    function automatic logic mgrant();
        if (m_left > 0) return m_src;
        if (in0_valid && !in1_valid) return 1'b0;
        if (in1_valid && !in0_valid) return 1'b1;
        return m_ptr;
    endfunction

    function automatic logic [1:0] mready();
        logic g;
        logic sp;
        g  = mgrant();
        sp = !m_ov || out_ready;
        return {sp && !g, sp && g};
    endfunction

    function automatic logic [19:0] mvec();
        return {m_ov, m_so, m_la, m_op, m_pa, m_sz, m_ad};
    endfunction

    // Advance one clock and update the model with whatever moved.
    task automatic tick();
        logic       g, a;
        logic [2:0] op, pa;
        logic [1:0] sz;
        logic [8:0] ad;
        g  = mgrant();
        a  = (!m_ov || out_ready) && (g ? in1_valid : in0_valid);
        op = g ? in1_opcode  : in0_opcode;
        pa = g ? in1_param   : in0_param;
        sz = g ? in1_size    : in0_size;
        ad = g ? in1_address : in0_address;
        acc0 = a && !g;
        acc1 = a && g;
        @(posedge clock);
        if (a) begin
            if (m_left == 0) begin
                m_left = ((op == 3'd0 || op == 3'd1) && sz == 2'd3) ? 2 : 1;
                m_src  = g;
            end
            m_left = m_left - 1;
            m_ov = 1'b1; m_so = g; m_la = (m_left == 0);
            m_op = op; m_pa = pa; m_sz = sz; m_ad = ad;
            if (m_la) m_ptr = !g;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input int port, input logic v, input logic [2:0] op,
                         input logic [1:0] sz, input logic [8:0] ad);
        if (port == 0) begin
            in0_valid = v; in0_opcode = op; in0_param = 3'd0; in0_size = sz; in0_address = ad;
        end else begin
            in1_valid = v; in1_opcode = op; in1_param = 3'd0; in1_size = sz; in1_address = ad;
        end
    endtask

    // ---------------- downstream channel monitor ----------------
    logic [19:0] p_vec;
    logic        p_v, p_r, p_rst;
    initial begin p_v = 1'b0; p_r = 1'b0; p_rst = 1'b0; p_vec = '0; end
    always @(negedge clock) begin
        if (p_rst && reset_n && p_v && !p_r) begin
            n_cmp++;
            if (dut_out !== p_vec) begin
                n_bad++;
                $display("FAIL monitor_stall_hold: got %h want %h", dut_out, p_vec);
            end
        end
        p_vec = dut_out; p_v = out_valid; p_r = out_ready; p_rst = reset_n;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        n_cmp++;
        if (dut_out !== 20'd0) begin n_bad++; $display("FAIL reset_out: got %h want %h", dut_out, 20'd0); end
        n_cmp++;
        if (dut_rdy !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want %b", dut_rdy, 2'b00); end
        @(negedge clock); #1;
        reset_n = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (dut_rdy !== 2'b10) begin n_bad++; $display("FAIL idle_ready: got %b want %b", dut_rdy, 2'b10); end
    endtask

    task automatic test_alternate();
        logic [19:0] exp;
        logic        s;
        drive(0, 1'b1, 3'd4, 2'd2, 9'h010);
        drive(1, 1'b1, 3'd4, 2'd2, 9'h020);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s = i[0];
            #1;
            n_cmp++;
            if (dut_rdy !== (s ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL alt_ready[%0d]: got %b want %b", i, dut_rdy, s ? 2'b01 : 2'b10);
            end
            tick();
            exp = {1'b1, s, 1'b1, 3'd4, 3'd0, 2'd2, s ? 9'h020 : 9'h010};
            n_cmp++;
            if (dut_out !== exp) begin n_bad++; $display("FAIL alt_out[%0d]: got %h want %h", i, dut_out, exp); end
        end
    endtask

    task automatic test_lock();
        logic [19:0] exp [7];
        logic [1:0]  rdy [7];
        exp[0] = {1'b1, 1'b0, 1'b1, 3'd4, 3'd0, 2'd2, 9'h010}; rdy[0] = 2'b10;
        exp[1] = {1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3, 9'h040}; rdy[1] = 2'b01;
        exp[2] = {1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 2'd3, 9'h044}; rdy[2] = 2'b01;
        exp[3] = {1'b1, 1'b0, 1'b1, 3'd4, 3'd0, 2'd2, 9'h010}; rdy[3] = 2'b10;
        exp[4] = {1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3, 9'h040}; rdy[4] = 2'b01;
        exp[5] = {1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3, 9'h040}; rdy[5] = 2'b01;
        exp[6] = {1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 2'd3, 9'h044}; rdy[6] = 2'b01;
        drive(0, 1'b1, 3'd4, 2'd2, 9'h010);
        drive(1, 1'b1, 3'd0, 2'd3, 9'h040);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 2 || i == 6) in1_address = 9'h044;
            if (i == 3) in1_valid = 1'b0;
            if (i == 4) begin in1_valid = 1'b1; in1_address = 9'h040; end
            if (i == 5) in1_valid = 1'b0;   // owner stalls mid-message
            #1;
            n_cmp++;
            if (dut_rdy !== rdy[i]) begin n_bad++; $display("FAIL lock_ready[%0d]: got %b want %b", i, dut_rdy, rdy[i]); end
            if (i == 6) in1_valid = 1'b1;
            tick();
            n_cmp++;
            if (dut_out !== exp[i]) begin n_bad++; $display("FAIL lock_out[%0d]: got %h want %h", i, dut_out, exp[i]); end
        end
        in1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [19:0] saved, exp;
        logic        s;
        drive(0, 1'b1, 3'd4, 2'd2, 9'h010);
        drive(1, 1'b1, 3'd4, 2'd2, 9'h020);
        out_ready = 1'b1;
        #1;
        tick();
        saved = mvec();
        s     = m_so;
        n_cmp++;
        if (dut_out !== saved) begin n_bad++; $display("FAIL bp_load: got %h want %h", dut_out, saved); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (dut_rdy !== 2'b00) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want %b", i, dut_rdy, 2'b00); end
            tick();
            n_cmp++;
            if (dut_out !== saved) begin n_bad++; $display("FAIL bp_hold[%0d]: got %h want %h", i, dut_out, saved); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (dut_rdy !== (s ? 2'b10 : 2'b01)) begin
            n_bad++; $display("FAIL bp_release_ready: got %b want %b", dut_rdy, s ? 2'b10 : 2'b01);
        end
        tick();
        exp = {1'b1, !s, 1'b1, 3'd4, 3'd0, 2'd2, s ? 9'h010 : 9'h020};
        n_cmp++;
        if (dut_out !== exp) begin n_bad++; $display("FAIL bp_next: got %h want %h", dut_out, exp); end
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp;
        drive(0, 1'b0, 3'd4, 2'd2, 9'h010);
        drive(1, 1'b1, 3'd0, 2'd3, 9'h040);
        out_ready = 1'b1;
        #1;
        tick();
        exp = {1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3, 9'h040};
        n_cmp++;
        if (dut_out !== exp) begin n_bad++; $display("FAIL rm_beat0: got %h want %h", dut_out, exp); end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_out !== 20'd0) begin n_bad++; $display("FAIL rm_out: got %h want %h", dut_out, 20'd0); end
        n_cmp++;
        if (dut_rdy !== 2'b00) begin n_bad++; $display("FAIL rm_ready: got %b want %b", dut_rdy, 2'b00); end
        @(negedge clock); #1;
        reset_n = 1'b1;
        model_reset();
        drive(0, 1'b1, 3'd4, 2'd2, 9'h010);
        drive(1, 1'b1, 3'd4, 2'd2, 9'h020);
        #1;
        n_cmp++;
        if (dut_rdy !== 2'b10) begin n_bad++; $display("FAIL rm_after_ready: got %b want %b", dut_rdy, 2'b10); end
        tick();
        exp = {1'b1, 1'b0, 1'b1, 3'd4, 3'd0, 2'd2, 9'h010};
        n_cmp++;
        if (dut_out !== exp) begin n_bad++; $display("FAIL rm_after_out: got %h want %h", dut_out, exp); end
    endtask

    task automatic test_single_source();
        logic [19:0] exp;
        in0_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 3'd4, 2'd2, 9'h100 + 9'(i));
            #1;
            n_cmp++;
            if (dut_rdy !== 2'b01) begin n_bad++; $display("FAIL ss_ready[%0d]: got %b want %b", i, dut_rdy, 2'b01); end
            tick();
            exp = {1'b1, 1'b1, 1'b1, 3'd4, 3'd0, 2'd2, 9'h100 + 9'(i)};
            n_cmp++;
            if (dut_out !== exp) begin n_bad++; $display("FAIL ss_out[%0d]: got %h want %h", i, dut_out, exp); end
        end
        // Pointer should now favour input 0 when both compete.
        drive(0, 1'b1, 3'd4, 2'd2, 9'h010);
        #1;
        n_cmp++;
        if (dut_rdy !== 2'b10) begin n_bad++; $display("FAIL ss_ptr: got %b want %b", dut_rdy, 2'b10); end
    endtask

    task automatic rand_beat(input int port);
        logic [2:0] op;
        op = 3'($urandom_range(0, 3));
        if (op == 3'd3) op = 3'd4;
        drive(port, $urandom_range(0, 3) != 0, op, 2'($urandom_range(0, 3)), 9'($urandom));
        if (port == 0) in0_param = 3'($urandom);
        else           in1_param = 3'($urandom);
    endtask

    task automatic test_random();
        logic [1:0] er;
        for (int i = 0; i < 600; i++) begin
            // Inputs hold their beat until it is taken.
            if (!in0_valid || acc0) rand_beat(0);
            if (!in1_valid || acc1) rand_beat(1);
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            er = mready();
            n_cmp++;
            if (dut_rdy !== er) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, dut_rdy, er); end
            tick();
            n_cmp++;
            if (dut_out !== mvec()) begin n_bad++; $display("FAIL rnd_out[%0d]: got %h want %h", i, dut_out, mvec()); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        out_ready = 1'b0;
        drive(0, 1'b0, 3'd0, 2'd0, 9'd0);
        drive(1, 1'b0, 3'd0, 2'd0, 9'd0);
        model_reset();
        test_reset();
        test_alternate();
        test_lock();
        test_backpressure();
        test_reset_mid();
        test_single_source();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tl_a_arbiter.md
TL_A_ARBITER -- requirements
Module: tl_a_arbiter

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-003 The block SHALL have ports in0_valid (input, 1) and in0_ready (output, 1): input 0 handshake.
REQ-004 The block SHALL have input 0 payload ports in0_opcode (input, 3), in0_param (input, 3), in0_size (input, 2) and in0_address (input, 9).
REQ-005 The block SHALL have ports in1_valid, in1_ready, in1_opcode, in1_param, in1_size and in1_address with the same directions and widths as the input 0 ports: input 1.
REQ-006 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream A-channel handshake, feeding the channel monitor.
REQ-007 The block SHALL have output payload ports out_opcode (3), out_param (3), out_size (2) and out_address (9).
REQ-008 The block SHALL have port out_source, output, 1 bit: index of the input that supplied the beat.
REQ-009 The block SHALL have port out_last, output, 1 bit: the beat is the final beat of its message.

Function
REQ-010 The block SHALL merge two TileLink A-channel sources into one registered output stage with exactly 1 beat of storage.
REQ-011 The block SHALL complete an input handshake only when inX_valid and inX_ready are both 1 in the same cycle.
REQ-012 The block SHALL drive inX_ready = grantX & (!out_valid | out_ready), combinationally, with no dependence on inX_valid of the same input.
REQ-013 The block SHALL capture an accepted beat into the output register on the same edge, so the beat is visible on out_* 1 cycle after acceptance.
REQ-014 The block SHALL support full throughput: if out_valid & out_ready & an input accept occur together, the register reloads with no bubble.
REQ-015 The block SHALL clear out_valid on out_valid & out_ready when no input beat is accepted in that cycle.
REQ-016 The block SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-017 The block SHALL classify a message as multi-beat when opcode is 0 or 1 (PutFull/PutPartial) and size=3, giving 2 beats; all other messages are single-beat.
REQ-018 The block SHALL keep arbitration state as: ptr (1 bit), locked (1 bit), lock_src (1 bit), beat (1 bit).
REQ-019 The block SHALL grant, when unlocked and only one input is valid, that input.
REQ-020 The block SHALL grant, when unlocked and both inputs are valid, input ptr.
REQ-021 The block SHALL grant, when unlocked and neither input is valid, input ptr so that ready is defined.
REQ-022 The block SHALL, while locked, grant only lock_src and hold the other input's ready at 0 regardless of its valid.
REQ-023 The block SHALL, on accepting beat 0 of a multi-beat message, set locked=1, lock_src to the source and beat=1, with out_last=0 for that beat.
REQ-024 The block SHALL, on accepting beat 1, clear locked and beat, with out_last=1.
REQ-025 The block SHALL drive out_last=1 for every single-beat message.
REQ-026 The block SHALL, on accepting a beat with out_last=1 from input i, set ptr to !i (round-robin); ptr is unchanged on non-last beats.
REQ-027 The block SHALL pass the beat-1 payload through unchanged and SHALL NOT check it against beat 0; beat 1 is treated as last regardless of its own size/opcode.
REQ-028 The block SHALL keep the registered out_source equal to the granted input index at capture.
REQ-029 The block SHALL keep locked=1 indefinitely when lock_src drops valid mid-message, stalling the other input.

Reset
REQ-030 The block SHALL, on reset_n=0, immediately drive out_valid=0 and set ptr=0, locked=0, lock_src=0 and beat=0.
REQ-031 The block SHALL, on reset_n=0, immediately drive out_opcode, out_param, out_size, out_address, out_source and out_last to 0.
REQ-032 The block SHALL drive in0_ready=0 and in1_ready=0 while reset_n=0.
REQ-033 The block SHALL, after reset deasserts, operate from the first rising edge with in0_ready=1 and in1_ready=0 when idle.
REQ-034 The block SHALL, on reset mid-message, discard the lock and partial message; no recovery is attempted.

Verification
REQ-035 The bench SHALL drive, after reset, both inputs valid with single-beat Get (opcode 4, size 2), address 0x010 on in0 and 0x020 on in1, out_ready=1 -> outputs alternate source 0,1,0,1..., one beat per cycle, out_last=1.
REQ-036 The bench SHALL drive in1 PutFull size 3, addresses 0x040 then 0x044, while in0 is continuously valid -> out_source=1 for both beats, in0_ready=0 between them, out_last 0 then 1, then in0 granted.
REQ-037 The bench SHALL hold out_ready=0 for 5 cycles with out_valid=1 -> out_* unchanged, both in_ready=0; on release the next beat follows with no bubble.
REQ-038 The bench SHALL assert reset_n=0 after beat 0 of a 2-beat put -> out_valid=0 immediately, locked cleared; after release, in0 is granted first.
REQ-039 The bench SHALL hold only in1 valid for 3 single beats -> all 3 accepted back-to-back; ptr ends at 0.
REQ-040 The bench SHALL run all scenarios with the downstream channel monitor attached -> no protocol assertion fires.
